// File: rtl/btc_dec_comp_code_sink_gen.sv
// Output sink for the BTC component-code decoder array.
// Column mode registers the parallel lane outputs straight through. Row mode
// assembles each lane's serial words into pDEC_NUM-wide vectors, holds one
// finished vector per lane and drains them lowest-lane-first. A two-stage
// path produces a saturating per-frame bit-error count.
module btc_dec_comp_code_sink_gen #(
    parameter int pEXTR_W  = 5,
    parameter int pERR_W   = 16,
    parameter int pDEC_NUM = 8
) (
    input  logic                          iclk,
    input  logic                          ireset,
    input  logic                          iclkena,
    input  logic                          irow_mode,
    input  logic [pDEC_NUM-1:0]           ival,
    input  logic [pDEC_NUM-1:0]           isof,
    input  logic [pDEC_NUM-1:0]           ieof,
    input  logic [pDEC_NUM-1:0]           imask,
    input  logic [pDEC_NUM*pEXTR_W-1:0]   iLextr,
    input  logic [pDEC_NUM-1:0]           ibitdat,
    input  logic [pDEC_NUM-1:0]           ibiterr,
    output logic                          oval,
    output logic                          osof,
    output logic                          oeof,
    output logic [pDEC_NUM*pEXTR_W-1:0]   oLextr,
    output logic [pDEC_NUM-1:0]           obitdat,
    output logic [pERR_W-1:0]             obiterr,
    output logic                          oerr_val,
    output logic                          oerr_zero,
    output logic                          ooverflow
);

    localparam int CNT_W = $clog2(pDEC_NUM);
    localparam int VEC_W = pDEC_NUM * pEXTR_W;
    localparam int PC_W  = $clog2(pDEC_NUM + 1);
    localparam int SUM_W = ((pERR_W > PC_W) ? pERR_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(pDEC_NUM - 1);
    localparam logic [SUM_W-1:0] ERR_MAX   = SUM_W'({pERR_W{1'b1}});

    logic                mode_q;
    logic                mode_chg;
    logic [CNT_W-1:0]    cnt_q        [pDEC_NUM];
    logic [CNT_W-1:0]    cnt_d        [pDEC_NUM];
    logic [VEC_W-1:0]    asm_lextr_q  [pDEC_NUM];
    logic [VEC_W-1:0]    asm_lextr_d  [pDEC_NUM];
    logic [pDEC_NUM-1:0] asm_bit_q    [pDEC_NUM];
    logic [pDEC_NUM-1:0] asm_bit_d    [pDEC_NUM];
    logic [pDEC_NUM-1:0] asm_sof_q, asm_sof_d;
    logic [VEC_W-1:0]    hold_lextr_q [pDEC_NUM];
    logic [VEC_W-1:0]    hold_lextr_d [pDEC_NUM];
    logic [pDEC_NUM-1:0] hold_bit_q   [pDEC_NUM];
    logic [pDEC_NUM-1:0] hold_bit_d   [pDEC_NUM];
    logic [pDEC_NUM-1:0] hold_sof_q, hold_sof_d, hold_eof_q, hold_eof_d;
    logic [pDEC_NUM-1:0] pend_q, pend_d, grant;
    logic                ovf_q, ovf_d;

    logic                oval_q, oval_d, osof_q, osof_d, oeof_q, oeof_d;
    logic [VEC_W-1:0]    olextr_q, olextr_d;
    logic [pDEC_NUM-1:0] obitdat_q, obitdat_d;

    // current word merged into each lane's partial vector
    logic [CNT_W-1:0]    slot_w [pDEC_NUM];
    logic [VEC_W-1:0]    lex_w  [pDEC_NUM];
    logic [pDEC_NUM-1:0] bit_w  [pDEC_NUM];
    logic [pDEC_NUM-1:0] sof_w, done_w;

    logic [pDEC_NUM-1:0] err_e_q;
    logic                err_sop_q, err_any_q, err_eop_q;
    logic [pERR_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]    acc_sum;
    logic                err_val_q, err_zero_q;

    assign mode_chg = irow_mode ^ mode_q;
    // isolate lowest pending lane
    assign grant    = pend_q & (~pend_q + pDEC_NUM'(1));

    // merge the incoming word into its slot; isof restarts the vector at slot 0
    always_comb begin
        for (int g = 0; g < pDEC_NUM; g++) begin
            slot_w[g] = isof[g] ? '0 : cnt_q[g];
            lex_w[g]  = isof[g] ? '0 : asm_lextr_q[g];
            bit_w[g]  = isof[g] ? '0 : asm_bit_q[g];
            sof_w[g]  = isof[g] ? 1'b0 : asm_sof_q[g];
            lex_w[g][int'(slot_w[g]) * pEXTR_W +: pEXTR_W] = iLextr[g * pEXTR_W +: pEXTR_W];
            bit_w[g][slot_w[g]] = ibitdat[g];
            if (slot_w[g] == '0) sof_w[g] = isof[g];
            done_w[g] = ival[g] & ((slot_w[g] == LAST_SLOT) | ieof[g]);
        end
    end

    // lane assembly, holding buffers, pending flags and overflow
    always_comb begin
        cnt_d        = cnt_q;
        asm_lextr_d  = asm_lextr_q;
        asm_bit_d    = asm_bit_q;
        asm_sof_d    = asm_sof_q;
        hold_lextr_d = hold_lextr_q;
        hold_bit_d   = hold_bit_q;
        hold_sof_d   = hold_sof_q;
        hold_eof_d   = hold_eof_q;
        pend_d       = pend_q;
        ovf_d        = ovf_q;
        if (!irow_mode || mode_chg) begin
            for (int g = 0; g < pDEC_NUM; g++) begin
                cnt_d[g]       = '0;
                asm_lextr_d[g] = '0;
                asm_bit_d[g]   = '0;
            end
            asm_sof_d = '0;
            pend_d    = '0;
        end else begin
            pend_d = pend_q & ~grant;
            for (int g = 0; g < pDEC_NUM; g++) begin
                if (done_w[g]) begin
                    // overwriting a buffer nobody has read yet loses a vector
                    if (pend_q[g] && !grant[g]) ovf_d = 1'b1;
                    hold_lextr_d[g] = lex_w[g];
                    hold_bit_d[g]   = bit_w[g];
                    hold_sof_d[g]   = sof_w[g];
                    hold_eof_d[g]   = ieof[g];
                    pend_d[g]       = 1'b1;
                    cnt_d[g]        = '0;
                    asm_lextr_d[g]  = '0;
                    asm_bit_d[g]    = '0;
                    asm_sof_d[g]    = 1'b0;
                end else if (ival[g]) begin
                    cnt_d[g]       = slot_w[g] + CNT_W'(1);
                    asm_lextr_d[g] = lex_w[g];
                    asm_bit_d[g]   = bit_w[g];
                    asm_sof_d[g]   = sof_w[g];
                end
            end
        end
    end

    // output register source: lane 0 bypass in column mode, granted buffer in row mode
    always_comb begin
        oval_d    = 1'b0;
        osof_d    = 1'b0;
        oeof_d    = 1'b0;
        olextr_d  = olextr_q;
        obitdat_d = obitdat_q;
        if (!irow_mode) begin
            oval_d    = ival[0];
            osof_d    = isof[0];
            oeof_d    = ieof[0];
            olextr_d  = iLextr;
            obitdat_d = ibitdat;
        end else if (!mode_chg) begin
            for (int g = 0; g < pDEC_NUM; g++) begin
                if (grant[g]) begin
                    oval_d    = 1'b1;
                    osof_d    = hold_sof_q[g];
                    oeof_d    = hold_eof_q[g];
                    olextr_d  = hold_lextr_q[g];
                    obitdat_d = hold_bit_q[g];
                end
            end
        end
    end

    // saturating error accumulator; sop restarts the count
    always_comb begin
        acc_sum = (err_sop_q ? '0 : SUM_W'(acc_q)) + SUM_W'($countones(err_e_q));
        acc_d   = acc_q;
        if (err_any_q) acc_d = (acc_sum > ERR_MAX) ? {pERR_W{1'b1}} : acc_sum[pERR_W-1:0];
    end

    // all state registers, frozen while iclkena is low
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            mode_q     <= 1'b0;
            for (int g = 0; g < pDEC_NUM; g++) begin
                cnt_q[g]        <= '0;
                asm_lextr_q[g]  <= '0;
                asm_bit_q[g]    <= '0;
                hold_lextr_q[g] <= '0;
                hold_bit_q[g]   <= '0;
            end
            asm_sof_q  <= '0;
            hold_sof_q <= '0;
            hold_eof_q <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            oval_q     <= 1'b0;
            osof_q     <= 1'b0;
            oeof_q     <= 1'b0;
            olextr_q   <= '0;
            obitdat_q  <= '0;
            err_e_q    <= '0;
            err_sop_q  <= 1'b0;
            err_any_q  <= 1'b0;
            err_eop_q  <= 1'b0;
            acc_q      <= '0;
            err_val_q  <= 1'b0;
            err_zero_q <= 1'b0;
        end else if (iclkena) begin
            mode_q       <= irow_mode;
            cnt_q        <= cnt_d;
            asm_lextr_q  <= asm_lextr_d;
            asm_bit_q    <= asm_bit_d;
            asm_sof_q    <= asm_sof_d;
            hold_lextr_q <= hold_lextr_d;
            hold_bit_q   <= hold_bit_d;
            hold_sof_q   <= hold_sof_d;
            hold_eof_q   <= hold_eof_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            oval_q       <= oval_d;
            osof_q       <= osof_d;
            oeof_q       <= oeof_d;
            olextr_q     <= olextr_d;
            obitdat_q    <= obitdat_d;
            err_e_q      <= ibiterr & ival & ~imask;
            err_sop_q    <= ival[0] & isof[0];
            err_any_q    <= |ival;
            err_eop_q    <= irow_mode ? |(ival & ieof) : (ival[0] & ieof[0]);
            acc_q        <= acc_d;
            err_val_q    <= err_eop_q;
            err_zero_q   <= (acc_d == '0);
        end
    end

    assign oval      = oval_q;
    assign osof      = osof_q;
    assign oeof      = oeof_q;
    assign oLextr    = olextr_q;
    assign obitdat   = obitdat_q;
    assign obiterr   = acc_q;
    assign oerr_val  = err_val_q;
    assign oerr_zero = err_zero_q;
    assign ooverflow = ovf_q;

endmodule

// File: tb/tb_btc_dec_comp_code_sink_gen.sv
// Bench for btc_dec_comp_code_sink_gen: directed scenarios plus random traffic
// against a vector/queue-level reference model. A second instance with a
// 4-bit error counter shares the stimulus to exercise saturation.
module tb_btc_dec_comp_code_sink_gen;

    localparam int N  = 8;
    localparam int EW = 5;
    localparam int VW = N * EW;

    logic          iclk = 1'b0;
    logic          ireset, iclkena, irow_mode;
    logic [N-1:0]  ival, isof, ieof, imask, ibitdat, ibiterr;
    logic [VW-1:0] iLextr;

    logic          oval, osof, oeof, oerr_val, oerr_zero, ooverflow;
    logic [VW-1:0] oLextr;
    logic [N-1:0]  obitdat;
    logic [15:0]   obiterr;

    logic          s_oval, s_osof, s_oeof, s_oerr_val, s_oerr_zero, s_ooverflow;
    logic [VW-1:0] s_oLextr;
    logic [N-1:0]  s_obitdat;
    logic [3:0]    s_obiterr;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int m_mode;
    int m_cnt [N];
    int m_lex [N][N];
    int m_bit [N][N];
    int m_sof [N];
    int h_lex [N][N];
    int h_bit [N][N];
    int h_sof [N];
    int h_eof [N];
    int m_pend[N];
    int m_ovf;
    int x_val, x_sof, x_eof;
    logic [VW-1:0] x_lex;
    logic [N-1:0]  x_bit;
    int s1_pc, s1_sop, s1_any, s1_eop;
    int acc16, acc4, x_errval;

    logic [VW-1:0] ev;
    int            nval;

    btc_dec_comp_code_sink_gen #(.pEXTR_W(EW), .pERR_W(16), .pDEC_NUM(N)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .irow_mode(irow_mode),
        .ival(ival), .isof(isof), .ieof(ieof), .imask(imask), .iLextr(iLextr),
        .ibitdat(ibitdat), .ibiterr(ibiterr),
        .oval(oval), .osof(osof), .oeof(oeof), .oLextr(oLextr), .obitdat(obitdat),
        .obiterr(obiterr), .oerr_val(oerr_val), .oerr_zero(oerr_zero), .ooverflow(ooverflow)
    );

    btc_dec_comp_code_sink_gen #(.pEXTR_W(EW), .pERR_W(4), .pDEC_NUM(N)) dut_sat (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .irow_mode(irow_mode),
        .ival(ival), .isof(isof), .ieof(ieof), .imask(imask), .iLextr(iLextr),
        .ibitdat(ibitdat), .ibiterr(ibiterr),
        .oval(s_oval), .osof(s_osof), .oeof(s_oeof), .oLextr(s_oLextr), .obitdat(s_obitdat),
        .obiterr(s_obiterr), .oerr_val(s_oerr_val), .oerr_zero(s_oerr_zero), .ooverflow(s_ooverflow)
    );

    always #5 iclk = ~iclk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic clear_lane(input int g);
        for (int s = 0; s < N; s++) begin
            m_lex[g][s] = 0;
            m_bit[g][s] = 0;
        end
        m_sof[g] = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_ovf = 0;
        for (int g = 0; g < N; g++) begin
            clear_lane(g);
            m_cnt[g] = 0; m_pend[g] = 0; h_sof[g] = 0; h_eof[g] = 0;
            for (int s = 0; s < N; s++) begin
                h_lex[g][s] = 0;
                h_bit[g][s] = 0;
            end
        end
        x_val = 0; x_sof = 0; x_eof = 0; x_lex = '0; x_bit = '0;
        s1_pc = 0; s1_sop = 0; s1_any = 0; s1_eop = 0;
        acc16 = 0; acc4 = 0; x_errval = 0;
    endtask

    // one enabled clock edge of the reference behaviour
    task automatic model_step();
        int pc, win, chg, s;
        if (!iclkena) return;
        if (s1_any != 0) begin
            acc16 = (s1_sop != 0) ? s1_pc : acc16 + s1_pc;
            acc4  = (s1_sop != 0) ? s1_pc : acc4 + s1_pc;
            if (acc16 > 65535) acc16 = 65535;
            if (acc4 > 15) acc4 = 15;
        end
        x_errval = s1_eop;
        pc = 0;
        for (int g = 0; g < N; g++) pc += int'(ibiterr[g] & ival[g] & ~imask[g]);
        s1_pc  = pc;
        s1_sop = int'(ival[0] & isof[0]);
        s1_any = int'(|ival);
        s1_eop = irow_mode ? int'(|(ival & ieof)) : int'(ival[0] & ieof[0]);

        chg = (int'(irow_mode) != m_mode);
        if (chg != 0) begin
            for (int g = 0; g < N; g++) begin
                clear_lane(g);
                m_cnt[g] = 0;
                m_pend[g] = 0;
            end
            m_mode = int'(irow_mode);
        end
        if (!irow_mode) begin
            x_val = ival[0]; x_sof = isof[0]; x_eof = ieof[0];
            x_lex = iLextr;  x_bit = ibitdat;
        end else begin
            x_val = 0; x_sof = 0; x_eof = 0; win = -1;
            for (int g = 0; g < N; g++) if (m_pend[g] != 0 && win < 0) win = g;
            if (win >= 0) begin
                x_val = 1; x_sof = h_sof[win]; x_eof = h_eof[win];
                for (int k = 0; k < N; k++) begin
                    x_lex[k*EW +: EW] = EW'(h_lex[win][k]);
                    x_bit[k] = h_bit[win][k][0];
                end
                m_pend[win] = 0;
            end
            if (chg == 0) begin
                for (int g = 0; g < N; g++) begin
                    if (ival[g]) begin
                        if (isof[g]) clear_lane(g);
                        s = isof[g] ? 0 : m_cnt[g];
                        m_lex[g][s] = int'(iLextr[g*EW +: EW]);
                        m_bit[g][s] = int'(ibitdat[g]);
                        if (s == 0) m_sof[g] = int'(isof[g]);
                        if (s == N - 1 || ieof[g]) begin
                            if (m_pend[g] != 0) m_ovf = 1;
                            for (int k = 0; k < N; k++) begin
                                h_lex[g][k] = m_lex[g][k];
                                h_bit[g][k] = m_bit[g][k];
                            end
                            h_sof[g] = m_sof[g];
                            h_eof[g] = int'(ieof[g]);
                            m_pend[g] = 1;
                            clear_lane(g);
                            m_cnt[g] = 0;
                        end else begin
                            m_cnt[g] = s + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk_val("oval", oval, x_val);
        chk_val("s_oval", s_oval, x_val);
        chk_val("ooverflow", ooverflow, m_ovf);
        chk_val("s_ooverflow", s_ooverflow, m_ovf);
        chk_val("oerr_val", oerr_val, x_errval);
        chk_val("obiterr", obiterr, acc16);
        chk_val("s_obiterr", s_obiterr, acc4);
        if (x_val != 0) begin
            chk_val("osof", osof, x_sof);
            chk_val("oeof", oeof, x_eof);
            chk_val("oLextr", oLextr, x_lex);
            chk_val("obitdat", obitdat, x_bit);
            chk_val("s_oLextr", s_oLextr, x_lex);
        end
        if (x_errval != 0) begin
            chk_val("oerr_zero", oerr_zero, acc16 == 0);
            chk_val("s_oerr_zero", s_oerr_zero, acc4 == 0);
        end
    endtask

    task automatic cyc();
        @(posedge iclk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle();
        ival = '0; isof = '0; ieof = '0; imask = '0;
        ibitdat = '0; ibiterr = '0; iLextr = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk_val({tag, "_out"}, {oval, osof, oeof, oerr_val, oerr_zero, ooverflow}, 6'b0);
        chk_val({tag, "_lex"}, oLextr, '0);
        chk_val({tag, "_bit"}, obitdat, '0);
        chk_val({tag, "_err"}, obiterr, '0);
        chk_val({tag, "_s"}, {s_oval, s_oerr_val, s_oerr_zero, s_ooverflow, s_obiterr}, '0);
    endtask

    task automatic err_frame(input logic [N-1:0] err, input logic [N-1:0] msk);
        for (int k = 0; k < 3; k++) begin
            ival = '1; ibiterr = err; imask = msk;
            isof = (k == 0) ? N'(1) : '0;
            ieof = (k == 2) ? N'(1) : '0;
            cyc();
        end
        idle();
        chk_val("err_not_yet", oerr_val, 1'b0);
        cyc();
        chk_val("err_val_t2", oerr_val, 1'b1);
    endtask

    initial begin
        ireset = 1'b1; iclkena = 1'b1; irow_mode = 1'b0;
        idle();
        model_reset();
        #12;
        check_all_zero("reset");
        ireset = 1'b0;

        // column bypass, 4 cycles of distinct data
        for (int k = 0; k < 4; k++) begin
            ival = '1;
            isof = (k == 0) ? N'(1) : '0;
            ieof = (k == 3) ? N'(1) : '0;
            for (int g = 0; g < N; g++) iLextr[g*EW +: EW] = EW'(k * 8 + g);
            ibitdat = N'(8'h5A + k);
            cyc();
            chk_val("col_val", oval, 1'b1);
            chk_val("col_lex", oLextr, iLextr);
            chk_val("col_bit", obitdat, ibitdat);
        end
        idle();
        cyc();
        chk_val("col_end", oval, 1'b0);

        // row mode, lane 3 alone, words 0..7
        irow_mode = 1'b1;
        cyc(); cyc();
        for (int k = 0; k < N; k++) begin
            idle();
            ival = N'(8'h08);
            isof = (k == 0) ? N'(8'h08) : '0;
            iLextr[3*EW +: EW] = EW'(k);
            cyc();
        end
        idle();
        chk_val("r3_t1", oval, 1'b0);
        cyc();
        for (int s = 0; s < N; s++) ev[s*EW +: EW] = EW'(s);
        chk_val("r3_val", oval, 1'b1);
        chk_val("r3_lex", oLextr, ev);
        chk_val("r3_sof", osof, 1'b1);
        chk_val("r3_eof", oeof, 1'b0);

        // all lanes complete together
        for (int k = 0; k < N; k++) begin
            ival = '1;
            isof = (k == 0) ? '1 : '0;
            for (int g = 0; g < N; g++) iLextr[g*EW +: EW] = EW'(g * 3 + k);
            ibitdat = N'($urandom());
            cyc();
        end
        idle();
        nval = 0;
        for (int k = 0; k < N + 2; k++) begin
            cyc();
            nval += int'(oval);
        end
        chk_val("all8_cnt", nval, N);
        chk_val("all8_ovf", ooverflow, 1'b0);

        // lane 0 back-to-back: 16 streaming words then 3 single-word vectors
        for (int k = 0; k < 2 * N; k++) begin
            idle(); ival = N'(1); isof = (k == 0) ? N'(1) : '0;
            iLextr[EW-1:0] = EW'(k);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            idle(); ival = N'(1); isof = N'(1); ieof = N'(1);
            iLextr[EW-1:0] = EW'(20 + k);
            cyc();
        end
        idle();
        cyc(); cyc();
        chk_val("b2b_ovf", ooverflow, 1'b0);

        // overflow: lanes 0 and 1 pending, lane 1 completes again while lane 0 drains
        idle(); ival = N'(3); isof = N'(3); ieof = N'(3);
        iLextr[EW-1:0] = EW'(3); iLextr[EW +: EW] = EW'(5);
        cyc();
        iclkena = 1'b0;
        ival = '1; isof = '1; ieof = '1; iLextr = '1;
        cyc(); cyc();
        chk_val("gate_hold", oval, 1'b0);
        iclkena = 1'b1;
        idle(); ival = N'(2); isof = N'(2); ieof = N'(2);
        iLextr[EW +: EW] = EW'(9);
        cyc();
        chk_val("ovf_set", ooverflow, 1'b1);
        idle();
        cyc();
        chk_val("ovf_val", oval, 1'b1);
        chk_val("ovf_lex", oLextr, VW'(9));
        cyc(); cyc();
        chk_val("ovf_sticky", ooverflow, 1'b1);

        // error counting in column mode
        irow_mode = 1'b0;
        cyc(); cyc();
        err_frame(N'(8'hFF), N'(8'h0F));
        chk_val("err12", obiterr, 16'd12);
        chk_val("err12_s", s_obiterr, 4'd12);
        chk_val("err12_z", oerr_zero, 1'b0);
        err_frame('0, '0);
        chk_val("err0", obiterr, 16'd0);
        chk_val("err0_z", oerr_zero, 1'b1);
        err_frame(N'(8'hFF), '0);
        chk_val("err24", obiterr, 16'd24);
        chk_val("err_sat", s_obiterr, 4'd15);

        // asynchronous reset in the middle of a frame
        ival = '1; ibiterr = '1; isof = N'(1);
        cyc();
        isof = '0;
        cyc();
        #3 ireset = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        #1 ireset = 1'b0;
        idle();
        cyc();

        // random traffic in alternating modes with random clock gating
        for (int blk = 0; blk < 4; blk++) begin
            irow_mode = blk[0];
            iclkena = 1'b1;
            idle();
            cyc(); cyc();
            for (int c = 0; c < 500; c++) begin
                iclkena = ($urandom_range(0, 7) != 0);
                for (int g = 0; g < N; g++) begin
                    ival[g] = ($urandom_range(0, 2) != 0);
                    isof[g] = ($urandom_range(0, 9) == 0);
                    ieof[g] = ($urandom_range(0, 7) == 0);
                end
                imask   = N'($urandom());
                ibitdat = N'($urandom());
                ibiterr = N'($urandom());
                iLextr  = VW'({$urandom(), $urandom()});
                cyc();
            end
        end
        iclkena = 1'b1;
        idle();
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
